// File: rtl/updown_counter.sv
// Parameterised up/down counter with clear, clamped load, saturate-or-wrap limits
// and registered overflow/underflow pulses.
module updown_counter #(
   parameter int unsigned      WIDTH   = 8,
   parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
   parameter bit               WRAP    = 1'b0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             inc,
   input  logic             dec,
   output logic [WIDTH-1:0] count,
   output logic             done,
   output logic             zero,
   output logic             ovf,
   output logic             unf
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic             up_step, down_step;
   logic             at_top, at_bottom;

   // Simultaneous inc and dec cancel out and count as no request.
   assign up_step   = inc & ~dec;
   assign down_step = dec & ~inc;
   assign at_top    = (count_q == MAX_VAL);
   assign at_bottom = (count_q == '0);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      count_d = count_q;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;

      if (clear) begin
         count_d = '0;
      end else if (load) begin
         count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
      end else if (up_step) begin
         if (at_top) begin
            ovf_d   = 1'b1;
            count_d = WRAP ? '0 : MAX_VAL;
         end else begin
            count_d = count_q + WIDTH'(1);
         end
      end else if (down_step) begin
         if (at_bottom) begin
            unf_d   = 1'b1;
            count_d = WRAP ? MAX_VAL : '0;
         end else begin
            count_d = count_q - WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign count = count_q;
   assign done  = at_top;
   assign zero  = at_bottom;
   assign ovf   = ovf_q;
   assign unf   = unf_q;

endmodule

// File: doc/updown_counter.md
UPDOWN_COUNTER -- requirements
Module: updown_counter

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits; SHALL be legal for 2..32.
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1, terminal (top) count; SHALL be legal for 1..2**WIDTH-1.
REQ-003 Parameter WRAP, default 0, boundary mode: 0 = saturate at the limits, 1 = wrap around.
REQ-004 Port clock, input, 1, sole clock; all state SHALL change on its rising edge.
REQ-005 Port reset, input, 1, asynchronous active-low reset.
REQ-006 Port clear, input, 1, synchronous clear to zero.
REQ-007 Port load, input, 1, synchronous load strobe.
REQ-008 Port load_val, input, WIDTH, value to load.
REQ-009 Port inc, input, 1, count-up request.
REQ-010 Port dec, input, 1, count-down request.
REQ-011 Port count, output, WIDTH, current count (registered).
REQ-012 Port done, output, 1, high while count == MAX_VAL.
REQ-013 Port zero, output, 1, high while count == 0.
REQ-014 Port ovf, output, 1, one-cycle registered pulse on an up-step at MAX_VAL.
REQ-015 Port unf, output, 1, one-cycle registered pulse on a down-step at 0.

Function
REQ-016 Per-edge priority SHALL be: clear, then load, then inc/dec.
REQ-017 With clear high, count SHALL become 0 on the next edge, and ovf/unf SHALL become 0.
REQ-018 With load high and clear low, count SHALL become min(load_val, MAX_VAL) on the next edge; inc/dec SHALL be ignored that cycle.
REQ-019 inc high and dec low, count < MAX_VAL: count SHALL become count+1 on the next edge (one-cycle latency).
REQ-020 dec high and inc low, count > 0: count SHALL become count-1 on the next edge.
REQ-021 inc and dec both high: count SHALL hold; ovf and unf SHALL be 0.
REQ-022 inc at count == MAX_VAL: WRAP=0 SHALL hold at MAX_VAL; WRAP=1 SHALL go to 0; both modes SHALL pulse ovf for exactly the following cycle.
REQ-023 dec at count == 0: WRAP=0 SHALL hold at 0; WRAP=1 SHALL go to MAX_VAL; both modes SHALL pulse unf for exactly the following cycle.
REQ-024 Count arithmetic SHALL be WIDTH bits, unsigned, with no carry beyond WIDTH; count SHALL never exceed MAX_VAL.
REQ-025 done and zero SHALL be combinational decodes of the count register; with MAX_VAL >= 1 they SHALL never be high together.
REQ-026 ovf and unf SHALL be registered, mutually exclusive, and 0 in any cycle following no boundary step.
REQ-027 Back-to-back inc cycles SHALL advance count by one per cycle, with no bubbles.

Reset
REQ-028 reset low SHALL immediately force count=0, ovf=0 and unf=0, independent of clock; zero SHALL be 1 and done SHALL be 0.
REQ-029 Deassertion of reset mid-operation SHALL resume counting from 0 on the first rising edge with reset high; no request held during reset SHALL be remembered.

Verification
REQ-030 WIDTH=3, MAX_VAL=7, WRAP=0: reset, then 9 inc cycles -> count 1..7 then holds 7; done=1 from the 7th edge; ovf pulses on the 8th and 9th edges.
REQ-031 WIDTH=3, MAX_VAL=5, WRAP=1: load 5, then inc -> count 0, ovf=1 for one cycle; then dec -> count 5, unf=1 for one cycle.
REQ-032 WIDTH=4, MAX_VAL=10: load_val=15 -> count 10, done=1; same cycle with inc=1 -> inc ignored.
REQ-033 Default parameters, count=4: clear, load and inc all high -> count 0; then inc and dec both high -> count holds at 0, no flags.
REQ-034 Default parameters, count=100 mid-increment: reset asserted asynchronously between edges -> count 0 before the next edge; after release, one inc -> count 1.
